// File: rtl/passthrough_stream_fifo_mc_pkg.sv
// Purpose: shared helpers for the multi-channel passthrough stream FIFO.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: ptr_dist() turns a phase-tagged read/write pointer pair into an occupancy count.
package passthrough_stream_fifo_mc_pkg;

    // Distance between write and read pointers. When the phases differ, the
    // write pointer has wrapped once more than the read pointer.
    function automatic int ptr_dist(input int wr_idx, input int rd_idx,
                                    input bit wr_ph, input bit rd_ph,
                                    input int depth);
        if (wr_ph == rd_ph) begin
            return wr_idx - rd_idx;
        end
        return depth - rd_idx + wr_idx;
    endfunction

endpackage

// File: rtl/passthrough_stream_fifo_ch.sv
// Purpose: one channel of the passthrough stream FIFO with registered usage and almost-full flag.
// Latency: 1 cycle push-to-valid, or 0 cycles through an empty channel when FallThrough is set.
// Backpressure: ready_o drops when full, unless SameCycleRW lets a same-cycle pop free the slot; flush forces both handshakes low.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i synchronous clear;
//        data_i/valid_i/ready_o push side; data_o/valid_o/ready_i pop side;
//        usage_o entries held (registered); almost_full_o usage >= AlmostFullThresh (registered).
module passthrough_stream_fifo_ch
    import passthrough_stream_fifo_mc_pkg::*;
#(
    parameter int unsigned Depth            = 8,
    parameter bit          SameCycleRW      = 1'b1,
    parameter bit          FallThrough      = 1'b0,
    parameter int unsigned AlmostFullThresh = Depth - 1,
    parameter type         type_t           = logic,
    localparam int unsigned PtrWidth        = $clog2(Depth),
    localparam int unsigned UsageWidth      = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  type_t                 data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output type_t                 data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [UsageWidth-1:0] usage_o,
    output logic                  almost_full_o
);

    logic [PtrWidth-1:0]   wr_idx_q, rd_idx_q;
    logic                  wr_ph_q, rd_ph_q;
    type_t                 mem_q [Depth];
    logic [UsageWidth-1:0] usage_q, usage_d;
    logic                  af_q, af_d;
    logic                  empty, full, push, pop, bypass, wr_en, rd_en;

    // Advance an index, wrapping at Depth-1 (not at a power of two) and
    // flipping the phase so full and empty stay distinguishable.
    function automatic logic [PtrWidth:0] ptr_incr(input logic [PtrWidth-1:0] idx,
                                                   input logic ph);
        if (idx == PtrWidth'(Depth - 1)) begin
            return {~ph, {PtrWidth{1'b0}}};
        end
        return {ph, idx + PtrWidth'(1)};
    endfunction

    assign empty = (wr_idx_q == rd_idx_q) && (wr_ph_q == rd_ph_q);
    assign full  = (wr_idx_q == rd_idx_q) && (wr_ph_q != rd_ph_q);

    assign valid_o = !flush_i && (!empty || (FallThrough && valid_i));
    // A full channel is never empty, so !empty stands in for valid_o here and
    // keeps valid_i out of the ready_o cone.
    assign ready_o = !flush_i && (!full || (SameCycleRW && ready_i && !empty));
    assign data_o  = (FallThrough && empty) ? data_i : mem_q[rd_idx_q];

    assign push   = valid_i && ready_o;
    assign pop    = valid_o && ready_i;
    // Empty fall-through push+pop: the beat goes straight across and never
    // touches storage, pointers or usage.
    assign bypass = FallThrough && empty && push && pop;
    assign wr_en  = push && !bypass;
    assign rd_en  = pop && !bypass;

    always_comb begin
        usage_d = usage_q;
        if (flush_i) begin
            usage_d = '0;
        end else if (wr_en && !rd_en) begin
            usage_d = usage_q + UsageWidth'(1);
        end else if (!wr_en && rd_en) begin
            usage_d = usage_q - UsageWidth'(1);
        end
        af_d = (usage_d >= UsageWidth'(AlmostFullThresh));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_idx_q <= '0;
            wr_ph_q  <= 1'b0;
            rd_idx_q <= '0;
            rd_ph_q  <= 1'b0;
            usage_q  <= '0;
            af_q     <= 1'b0;
        end else begin
            usage_q <= usage_d;
            af_q    <= af_d;
            if (flush_i) begin
                wr_idx_q <= '0;
                wr_ph_q  <= 1'b0;
                rd_idx_q <= '0;
                rd_ph_q  <= 1'b0;
            end else begin
                if (wr_en) begin
                    {wr_ph_q, wr_idx_q} <= ptr_incr(wr_idx_q, wr_ph_q);
                end
                if (rd_en) begin
                    {rd_ph_q, rd_idx_q} <= ptr_incr(rd_idx_q, rd_ph_q);
                end
            end
        end
    end

    // Each slot loads only when it is the one being written; flush leaves contents alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(Depth); i++) begin
                if (wr_en && (wr_idx_q == PtrWidth'(i))) begin
                    mem_q[i] <= data_i;
                end
            end
        end
    end

    assign usage_o       = usage_q;
    assign almost_full_o = af_q;

    a_push_rdy: assert property (@(posedge clk_i) disable iff (!rst_ni) (wr_en |-> ready_o));
    a_pop_vld:  assert property (@(posedge clk_i) disable iff (!rst_ni) (rd_en |-> valid_o));
    a_usage_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (usage_q <= UsageWidth'(Depth)));
    a_usage_dist: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (int'(usage_q) == ptr_dist(int'(wr_idx_q), int'(rd_idx_q), wr_ph_q, rd_ph_q, int'(Depth))));

endmodule

// File: rtl/passthrough_stream_fifo_mc.sv
// Purpose: NumChan independent passthrough stream FIFOs sharing one clock, with per-channel fill reporting.
// Latency: 1 cycle push-to-valid per channel, or 0 cycles through an empty channel when FallThrough is set.
// Backpressure: per-channel ready_o; a full channel still accepts when it pops in the same cycle if SameCycleRW.
// Ports: clk_i, rst_ni (async active-low), testmode_i (unused), flush_i[NumChan],
//        data_i/valid_i/ready_o, data_o/valid_o/ready_i, usage_o[NumChan], almost_full_o[NumChan].
module passthrough_stream_fifo_mc #(
    parameter int unsigned NumChan          = 2,
    parameter int unsigned Depth            = 8,
    parameter bit          SameCycleRW      = 1'b1,
    parameter bit          FallThrough      = 1'b0,
    parameter int unsigned AlmostFullThresh = Depth - 1,
    parameter type         type_t           = logic,
    localparam int unsigned UsageWidth      = $clog2(Depth + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                testmode_i,
    input  logic  [NumChan-1:0]                 flush_i,
    input  type_t [NumChan-1:0]                 data_i,
    input  logic  [NumChan-1:0]                 valid_i,
    output logic  [NumChan-1:0]                 ready_o,
    output type_t [NumChan-1:0]                 data_o,
    output logic  [NumChan-1:0]                 valid_o,
    input  logic  [NumChan-1:0]                 ready_i,
    output logic  [NumChan-1:0][UsageWidth-1:0] usage_o,
    output logic  [NumChan-1:0]                 almost_full_o
);

    if (NumChan < 1) begin : g_err_numchan
        $error("NumChan must be at least 1");
    end
    if (Depth < 2) begin : g_err_depth
        $error("Depth must be at least 2");
    end
    if ((AlmostFullThresh < 1) || (AlmostFullThresh > Depth)) begin : g_err_thresh
        $error("AlmostFullThresh must lie in 1..Depth");
    end

    // No clock gating inside, so the bypass has nothing to control.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    for (genvar c = 0; c < NumChan; c++) begin : g_ch
        passthrough_stream_fifo_ch #(
            .Depth            (Depth),
            .SameCycleRW      (SameCycleRW),
            .FallThrough      (FallThrough),
            .AlmostFullThresh (AlmostFullThresh),
            .type_t           (type_t)
        ) u_ch (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .flush_i       (flush_i[c]),
            .data_i        (data_i[c]),
            .valid_i       (valid_i[c]),
            .ready_o       (ready_o[c]),
            .data_o        (data_o[c]),
            .valid_o       (valid_o[c]),
            .ready_i       (ready_i[c]),
            .usage_o       (usage_o[c]),
            .almost_full_o (almost_full_o[c])
        );
    end

endmodule

// File: tb/tb_passthrough_stream_fifo_mc.sv
// Purpose: self-checking bench for passthrough_stream_fifo_mc (two configurations side by side).
// Latency: n/a.
// Backpressure: n/a.
module tb_passthrough_stream_fifo_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic testmode = 1'b0;

    // Instance A: 2 channels, Depth 5, SameCycleRW=1, FallThrough=0, threshold 4.
    logic [1:0]      a_flush, a_valid_i, a_ready_o, a_valid_o, a_ready_i, a_af;
    logic [1:0][7:0] a_data_i, a_data_o;
    logic [1:0][2:0] a_usage;

    // Instance B: 1 channel, Depth 5, SameCycleRW=0, FallThrough=1, threshold 4.
    logic [0:0]      b_flush, b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_af;
    logic [0:0][7:0] b_data_i, b_data_o;
    logic [0:0][2:0] b_usage;

    passthrough_stream_fifo_mc #(
        .NumChan(2), .Depth(5), .SameCycleRW(1'b1), .FallThrough(1'b0),
        .AlmostFullThresh(4), .type_t(logic [7:0])
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(testmode), .flush_i(a_flush),
        .data_i(a_data_i), .valid_i(a_valid_i), .ready_o(a_ready_o),
        .data_o(a_data_o), .valid_o(a_valid_o), .ready_i(a_ready_i),
        .usage_o(a_usage), .almost_full_o(a_af)
    );

    passthrough_stream_fifo_mc #(
        .NumChan(1), .Depth(5), .SameCycleRW(1'b0), .FallThrough(1'b1),
        .AlmostFullThresh(4), .type_t(logic [7:0])
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(testmode), .flush_i(b_flush),
        .data_i(b_data_i), .valid_i(b_valid_i), .ready_o(b_ready_o),
        .data_o(b_data_o), .valid_o(b_valid_o), .ready_i(b_ready_i),
        .usage_o(b_usage), .almost_full_o(b_af)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboards: expected contents per channel, pushed on accepted pushes.
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] qb [$];

    typedef struct {
        logic       v;
        logic       r;
        logic [7:0] d;
        logic       exp_rdy;
        logic       exp_vld;
        logic [7:0] exp_dat;
        int         exp_usage;
        logic       exp_af;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsz(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qhead(input int c);
        return (c == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_update(input int c, input bit fl, input bit pp, input bit ps, input logic [7:0] d);
        if (c == 0) begin
            if (fl) q0.delete();
            else begin
                if (pp) void'(q0.pop_front());
                if (ps) q0.push_back(d);
            end
        end else begin
            if (fl) q1.delete();
            else begin
                if (pp) void'(q1.pop_front());
                if (ps) q1.push_back(d);
            end
        end
    endtask

    // One cycle on instance A; called at posedge+1, returns at posedge+1.
    task automatic a_cycle(input logic [1:0] fl, input logic [1:0] v, input logic [1:0] r,
                           input logic [7:0] d0, input logic [7:0] d1);
        a_flush = fl; a_valid_i = v; a_ready_i = r;
        a_data_i[0] = d0; a_data_i[1] = d1;
        #1;
        for (int c = 0; c < 2; c++) begin
            bit ev, er;
            ev = !fl[c] && (qsz(c) > 0);
            er = !fl[c] && ((qsz(c) < 5) || (r[c] && qsz(c) > 0));
            chk($sformatf("a%0d valid_o", c), int'(a_valid_o[c]), int'(ev));
            chk($sformatf("a%0d ready_o", c), int'(a_ready_o[c]), int'(er));
            if (ev) chk($sformatf("a%0d data_o", c), int'(a_data_o[c]), int'(qhead(c)));
            q_update(c, fl[c], ev && r[c], er && v[c], (c == 0) ? d0 : d1);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("a%0d usage_o", c), int'(a_usage[c]), qsz(c));
            chk($sformatf("a%0d almost_full_o", c), int'(a_af[c]), int'(qsz(c) >= 4));
        end
        a_flush = '0; a_valid_i = '0; a_ready_i = '0;
    endtask

    // One cycle on instance B (fall-through, no same-cycle full accept).
    task automatic b_cycle(input logic fl, input logic v, input logic r, input logic [7:0] d);
        int sz;
        bit ev, er;
        logic [7:0] ed;
        sz = qb.size();
        b_flush[0] = fl; b_valid_i[0] = v; b_ready_i[0] = r; b_data_i[0] = d;
        #1;
        ev = !fl && ((sz > 0) || v);
        er = !fl && (sz < 5);
        ed = (sz > 0) ? qb[0] : d;
        chk("b valid_o", int'(b_valid_o[0]), int'(ev));
        chk("b ready_o", int'(b_ready_o[0]), int'(er));
        if (ev) chk("b data_o", int'(b_data_o[0]), int'(ed));
        if (fl) qb.delete();
        else if (!((sz == 0) && v && er && r)) begin
            if (ev && r && (sz > 0)) void'(qb.pop_front());
            if (v && er) qb.push_back(d);
        end
        @(posedge clk); #1;
        chk("b usage_o", int'(b_usage[0]), qb.size());
        chk("b almost_full_o", int'(b_af[0]), int'(qb.size() >= 4));
        b_flush = '0; b_valid_i = '0; b_ready_i = '0;
    endtask

    initial begin
        // Fill/drain table for A channel 0: 5 pushes, one stalled push, 5 pops.
        for (int i = 0; i < 5; i++) begin
            tbl[i] = '{v: 1'b1, r: 1'b0, d: 8'(i), exp_rdy: 1'b1, exp_vld: (i > 0),
                       exp_dat: 8'h00, exp_usage: i + 1, exp_af: (i + 1 >= 4)};
        end
        tbl[5] = '{v: 1'b1, r: 1'b0, d: 8'h99, exp_rdy: 1'b0, exp_vld: 1'b1,
                   exp_dat: 8'h00, exp_usage: 5, exp_af: 1'b1};
        for (int i = 0; i < 5; i++) begin
            tbl[6 + i] = '{v: 1'b0, r: 1'b1, d: 8'h00, exp_rdy: 1'b1, exp_vld: 1'b1,
                           exp_dat: 8'(i), exp_usage: 4 - i, exp_af: (4 - i >= 4)};
        end

        rst_n = 1'b0;
        a_flush = '0; a_valid_i = '0; a_ready_i = '0; a_data_i = '0;
        b_flush = '0; b_valid_i = '0; b_ready_i = '0; b_data_i = '0;
        #12;
        // Reset state, checked while reset is still held.
        chk("rst a ready_o", int'(a_ready_o), 3);
        chk("rst a valid_o", int'(a_valid_o), 0);
        chk("rst a usage0", int'(a_usage[0]), 0);
        chk("rst a usage1", int'(a_usage[1]), 0);
        chk("rst a almost_full", int'(a_af), 0);
        b_valid_i = 1'b1; b_data_i[0] = 8'h5A;
        #1;
        chk("rst b valid_o follows valid_i", int'(b_valid_o[0]), 1);
        chk("rst b ready_o", int'(b_ready_o[0]), 1);
        b_valid_i = 1'b0;
        #1;
        chk("rst b valid_o idle", int'(b_valid_o[0]), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven fill and drain.
        for (int i = 0; i < 11; i++) begin
            a_valid_i = {1'b0, tbl[i].v};
            a_ready_i = {1'b0, tbl[i].r};
            a_data_i[0] = tbl[i].d;
            #1;
            chk($sformatf("tbl%0d ready_o", i), int'(a_ready_o[0]), int'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d valid_o", i), int'(a_valid_o[0]), int'(tbl[i].exp_vld));
            if (tbl[i].exp_vld) chk($sformatf("tbl%0d data_o", i), int'(a_data_o[0]), int'(tbl[i].exp_dat));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d usage_o", i), int'(a_usage[0]), tbl[i].exp_usage);
            chk($sformatf("tbl%0d almost_full_o", i), int'(a_af[0]), int'(tbl[i].exp_af));
        end
        a_valid_i = '0; a_ready_i = '0;

        // Full with simultaneous push+pop across several wraps (SameCycleRW=1).
        for (int i = 0; i < 5; i++) a_cycle(2'b00, 2'b01, 2'b00, 8'h10 + 8'(i), 8'h00);
        for (int k = 0; k < 12; k++) a_cycle(2'b00, 2'b01, 2'b01, 8'hA0 + 8'(k), 8'h00);
        for (int i = 0; i < 5; i++) a_cycle(2'b00, 2'b00, 2'b01, 8'h00, 8'h00);

        // Fall-through bypass on an empty channel: zero latency, usage stays 0.
        b_cycle(1'b0, 1'b1, 1'b1, 8'h3C);
        // Fill B, then push+pop while full with SameCycleRW=0.
        for (int i = 0; i < 5; i++) b_cycle(1'b0, 1'b1, 1'b0, 8'h20 + 8'(i));
        for (int k = 0; k < 4; k++) b_cycle(1'b0, 1'b1, 1'b1, 8'h30 + 8'(k));
        for (int i = 0; i < 6; i++) b_cycle(1'b0, 1'b0, 1'b1, 8'h00);

        // Flush channel 1 at usage 3 while channel 0 streams.
        for (int i = 0; i < 3; i++) a_cycle(2'b00, 2'b11, 2'b01, 8'h50 + 8'(i), 8'h40 + 8'(i));
        a_cycle(2'b10, 2'b11, 2'b11, 8'h60, 8'h70);
        a_cycle(2'b00, 2'b11, 2'b01, 8'h61, 8'h71);
        for (int i = 0; i < 3; i++) a_cycle(2'b00, 2'b00, 2'b11, 8'h00, 8'h00);

        // Asynchronous reset mid-cycle at usage 4.
        for (int i = 0; i < 4; i++) a_cycle(2'b00, 2'b01, 2'b00, 8'h80 + 8'(i), 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst usage0", int'(a_usage[0]), 0);
        chk("arst almost_full0", int'(a_af[0]), 0);
        chk("arst valid_o", int'(a_valid_o), 0);
        chk("arst ready_o", int'(a_ready_o), 3);
        q0.delete(); q1.delete(); qb.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a_cycle(2'b00, 2'b01, 2'b00, 8'h55, 8'h00);
        a_cycle(2'b00, 2'b01, 2'b01, 8'h66, 8'h00);
        a_cycle(2'b00, 2'b00, 2'b01, 8'h00, 8'h00);

        // Random traffic on both instances.
        for (int k = 0; k < 300; k++) begin
            logic [1:0] fl;
            fl[0] = ($urandom_range(0, 19) == 0);
            fl[1] = ($urandom_range(0, 19) == 0);
            a_cycle(fl, 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
        end
        for (int k = 0; k < 200; k++) begin
            b_cycle(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
